// File: rtl/rr_lock_arb_if.sv
// Request/grant bundle between requesters (master) and the round-robin lock arbiter (slave).
interface rr_lock_arb_if #(
  parameter int NUM_REQ = 5
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grt;
  logic               grt_vld;
  logic [IDW-1:0]     grt_id;
  logic               timeout;

  modport master (output req, input grt, grt_vld, grt_id, timeout);
  modport slave  (input req, output grt, grt_vld, grt_id, timeout);
endinterface

// File: rtl/rr_lock_arb.sv
// Round-robin lock arbiter: a granted requester keeps the resource while its request stays high,
// up to MAX_HOLD cycles, with a mandatory idle bubble between grants.
module rr_lock_arb #(
  parameter int NUM_REQ  = 5,
  parameter int MAX_HOLD = 16
) (
  input logic          clk,
  input logic          rst_,
  rr_lock_arb_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int HW  = $clog2(MAX_HOLD);

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [NUM_REQ-1:0] grt_q, grt_d;
  logic               vld_q, vld_d;
  logic [IDW-1:0]     id_q, id_d;
  logic               timeout_q, timeout_d;
  logic [IDW-1:0]     win;
  logic [IDW-1:0]     ptr_nxt;

  // First asserted request scanning upward from the pointer, wrapping at NUM_REQ-1.
  function automatic logic [IDW-1:0] pick(input logic [NUM_REQ-1:0] r, input logic [IDW-1:0] p);
    logic           found;
    int             idx;
    logic [IDW-1:0] idx_v;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(p) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_v = IDW'(idx);
      if (!found && r[idx_v]) begin
        found = 1'b1;
        pick  = idx_v;
      end
    end
  endfunction

  assign win     = pick(bus.req, ptr_q);
  assign ptr_nxt = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    grt_d     = grt_q;
    vld_d     = vld_q;
    id_d      = id_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        grt_d = '0;
        vld_d = 1'b0;
        id_d  = '0;
        if (|bus.req) begin
          grt_d   = NUM_REQ'(1) << win;
          vld_d   = 1'b1;
          id_d    = win;
          hold_d  = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!bus.req[id_q] || hold_q == HW'(MAX_HOLD - 1)) begin
          timeout_d = bus.req[id_q];
          grt_d     = '0;
          vld_d     = 1'b0;
          id_d      = '0;
          hold_d    = '0;
          ptr_d     = ptr_nxt;
          state_d   = S_IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      grt_q     <= '0;
      vld_q     <= 1'b0;
      id_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      grt_q     <= grt_d;
      vld_q     <= vld_d;
      id_q      <= id_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grt     = grt_q;
  assign bus.grt_vld = vld_q;
  assign bus.grt_id  = id_q;
  assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_rr_lock_arb.sv
// Directed bench for rr_lock_arb with NUM_REQ=5, MAX_HOLD=16.
module tb_rr_lock_arb;
  logic clk = 1'b0;
  logic rst_;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  rr_lock_arb_if #(.NUM_REQ(5)) bus ();

  rr_lock_arb #(.NUM_REQ(5), .MAX_HOLD(16)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ = 1'b1;
    step();
    step();
    rst_ = 1'b0;
  endtask

  task automatic test_reset();
    rst_    = 1'b1;
    bus.req = 5'b11111;
    step();
    step();
    total++;
    if ({bus.grt, bus.grt_vld, bus.grt_id, bus.timeout} !== 10'b0) begin
      $display("FAIL reset_outputs: got grt=%b vld=%b id=%0d to=%b, need all zero",
               bus.grt, bus.grt_vld, bus.grt_id, bus.timeout);
    end else passed++;
    rst_    = 1'b0;
    bus.req = 5'b00000;
    step();
    step();
    total++;
    if ({bus.grt, bus.grt_vld} !== 6'b0) begin
      $display("FAIL idle_no_req: got grt=%b vld=%b, need 0/0", bus.grt, bus.grt_vld);
    end else passed++;
  endtask

  task automatic test_first_grant();
    do_reset();
    bus.req = 5'b10100;
    step();
    total++;
    if (bus.grt !== 5'b00100 || bus.grt_id !== 3'd2 || bus.grt_vld !== 1'b1) begin
      $display("FAIL first_grant: got grt=%b id=%0d vld=%b, need 00100/2/1",
               bus.grt, bus.grt_id, bus.grt_vld);
    end else passed++;
  endtask

  task automatic test_release_rotate();
    bus.req = 5'b11011;
    step();
    total++;
    if ({bus.grt, bus.grt_vld, bus.grt_id, bus.timeout} !== 10'b0) begin
      $display("FAIL release_bubble: got grt=%b vld=%b id=%0d to=%b, need all zero",
               bus.grt, bus.grt_vld, bus.grt_id, bus.timeout);
    end else passed++;
    bus.req = 5'b11111;
    step();
    total++;
    if (bus.grt !== 5'b01000 || bus.grt_id !== 3'd3) begin
      $display("FAIL release_next: got grt=%b id=%0d, need 01000/3", bus.grt, bus.grt_id);
    end else passed++;
    bus.req = 5'b00000;
    step();
    step();
  endtask

  task automatic test_timeout_single();
    int bad;
    do_reset();
    bus.req = 5'b00001;
    step();
    total++;
    if (bus.grt !== 5'b00001 || bus.timeout !== 1'b0) begin
      $display("FAIL single_grant: got grt=%b to=%b, need 00001/0", bus.grt, bus.timeout);
    end else passed++;
    bad = 0;
    for (int i = 1; i < 16; i++) begin
      step();
      if (bus.grt !== 5'b00001 || bus.timeout !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) begin
      $display("FAIL single_hold: got %0d bad cycles of 15, need 0", bad);
    end else passed++;
    step();
    total++;
    if (bus.grt !== 5'b00000 || bus.timeout !== 1'b1 || bus.grt_vld !== 1'b0) begin
      $display("FAIL single_timeout: got grt=%b to=%b vld=%b, need 00000/1/0",
               bus.grt, bus.timeout, bus.grt_vld);
    end else passed++;
    step();
    total++;
    if (bus.grt !== 5'b00001 || bus.timeout !== 1'b0) begin
      $display("FAIL single_regrant: got grt=%b to=%b, need 00001/0", bus.grt, bus.timeout);
    end else passed++;
    bus.req = 5'b00000;
    step();
    total++;
    if (bus.grt !== 5'b00000 || bus.timeout !== 1'b0) begin
      $display("FAIL voluntary_no_timeout: got grt=%b to=%b, need 00000/0", bus.grt, bus.timeout);
    end else passed++;
  endtask

  task automatic test_fair_rotation();
    int          bad;
    logic [4:0]  exp_g;
    logic [2:0]  exp_id;
    do_reset();
    bus.req = 5'b11111;
    for (int g = 0; g < 6; g++) begin
      exp_id = 3'(g % 5);
      exp_g  = 5'b00001 << exp_id;
      step();
      total++;
      if (bus.grt !== exp_g || bus.grt_id !== exp_id) begin
        $display("FAIL rotate_grant%0d: got grt=%b id=%0d, need %b/%0d",
                 g, bus.grt, bus.grt_id, exp_g, exp_id);
      end else passed++;
      bad = 0;
      for (int i = 1; i < 16; i++) begin
        step();
        if (bus.grt !== exp_g) bad++;
      end
      step();
      total++;
      if (bad != 0 || bus.grt !== 5'b00000 || bus.timeout !== 1'b1) begin
        $display("FAIL rotate_timeout%0d: got bad=%0d grt=%b to=%b, need 0/00000/1",
                 g, bad, bus.grt, bus.timeout);
      end else passed++;
    end
    bus.req = 5'b00000;
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.req = 5'b01000;
    step();
    bus.req = 5'b00000;
    step();
    bus.req = 5'b10011;
    step();
    total++;
    if (bus.grt !== 5'b10000 || bus.grt_id !== 3'd4) begin
      $display("FAIL wrap_grant4: got grt=%b id=%0d, need 10000/4", bus.grt, bus.grt_id);
    end else passed++;
    bus.req = 5'b10000;
    step();
    bus.req = 5'b11110;
    step();
    total++;
    if (bus.grt !== 5'b10000 || bus.grt_id !== 3'd4) begin
      $display("FAIL other_req_ignored: got grt=%b id=%0d, need 10000/4", bus.grt, bus.grt_id);
    end else passed++;
    bus.req = 5'b00011;
    step();
    total++;
    if (bus.grt !== 5'b00000) begin
      $display("FAIL wrap_bubble: got grt=%b, need 00000", bus.grt);
    end else passed++;
    step();
    total++;
    if (bus.grt !== 5'b00001 || bus.grt_id !== 3'd0) begin
      $display("FAIL wrap_grant0: got grt=%b id=%0d, need 00001/0", bus.grt, bus.grt_id);
    end else passed++;
    bus.req = 5'b00000;
    step();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    bus.req = 5'b01000;
    step();
    bus.req = 5'b01010;
    step();
    total++;
    if (bus.grt !== 5'b01000) begin
      $display("FAIL pre_reset_grant3: got grt=%b, need 01000", bus.grt);
    end else passed++;
    rst_ = 1'b1;
    step();
    total++;
    if (bus.grt !== 5'b00000 || bus.grt_vld !== 1'b0 || bus.grt_id !== 3'd0) begin
      $display("FAIL reset_drops_grant: got grt=%b vld=%b id=%0d, need 00000/0/0",
               bus.grt, bus.grt_vld, bus.grt_id);
    end else passed++;
    rst_ = 1'b0;
    step();
    total++;
    if (bus.grt !== 5'b00010 || bus.grt_id !== 3'd1) begin
      $display("FAIL post_reset_ptr0: got grt=%b id=%0d, need 00010/1", bus.grt, bus.grt_id);
    end else passed++;
    bus.req = 5'b00000;
    step();
  endtask

  initial begin
    rst_    = 1'b1;
    bus.req = '0;
    test_reset();
    test_first_grant();
    test_release_rotate();
    test_timeout_single();
    test_fair_rotation();
    test_wrap();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
